// File: rtl/gshare_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_pkg
// Description : Shared types, opcode constants and immediate extraction
//               helpers for the gshare branch direction predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package gshare_predictor_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;
    typedef logic [6:0]  opcode_t;

    localparam int      c_OPCODE_MSB  = 6;
    localparam int      c_OPCODE_LSB  = 0;
    localparam opcode_t c_OPCODE_JAL  = 7'b1101111;
    localparam opcode_t c_OPCODE_BR   = 7'b1100011;
    localparam opcode_t c_OPCODE_JALR = 7'b1100111;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    typedef enum logic [1:0] {
        INST_OTHER = 2'd0,
        INST_JAL   = 2'd1,
        INST_BR    = 2'd2,
        INST_JALR  = 2'd3
    } inst_kind_e;

    function automatic opcode_t get_opcode(input inst_t inst);
        return inst[c_OPCODE_MSB:c_OPCODE_LSB];
    endfunction

    function automatic inst_kind_e decode_kind(input inst_t inst);
        inst_kind_e kind;
        case (get_opcode(inst))
            c_OPCODE_JAL:  kind = INST_JAL;
            c_OPCODE_BR:   kind = INST_BR;
            c_OPCODE_JALR: kind = INST_JALR;
            default:       kind = INST_OTHER;
        endcase
        return kind;
    endfunction

    function automatic addr_t imm_j(input inst_t inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic addr_t imm_b(input inst_t inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter_next
// Description : Next-state function of a CNT_W-bit saturating up/down
//               counter; holds at all-ones on increment and zero on decrement.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_next
    import gshare_predictor_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_MIN = '0;

    always_comb begin
        o_cnt = i_cnt;
        if (i_inc == c_TRUE) begin
            if (i_cnt != c_CNT_MAX) begin
                o_cnt = i_cnt + CNT_W'(1);
            end
        end else if (i_cnt != c_CNT_MIN) begin
            o_cnt = i_cnt - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Conditional branch direction predictor. Saturating counter
//               table indexed by PC xor speculative global history (or PC
//               alone in bimodal mode), with ROB-driven history repair.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int INDEX_LEN = 8,
    parameter int CNT_W     = 2,
    parameter int GHR_LEN   = 8,
    parameter int GSHARE    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               query_valid,
    input  logic [31:0]        query_pc,
    input  logic [31:0]        query_inst,
    output logic               predicted_jump,
    output logic [31:0]        predicted_imm,
    output logic [GHR_LEN-1:0] predicted_ghr,
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic [GHR_LEN-1:0] upd_ghr,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
);

    localparam int               c_ENTRIES   = 1 << INDEX_LEN;
    localparam logic [CNT_W-1:0] c_CNT_RESET = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [31:0]      c_STAT_MAX  = 32'hFFFF_FFFF;

    logic [CNT_W-1:0]     r_table_q [c_ENTRIES];
    logic [GHR_LEN-1:0]   r_ghr_q;
    logic [GHR_LEN-1:0]   w_ghr_d;
    logic [31:0]          r_branches_q;
    logic [31:0]          w_branches_d;
    logic [31:0]          r_mispredicts_q;
    logic [31:0]          w_mispredicts_d;

    logic [INDEX_LEN-1:0] w_q_ghr_ext;
    logic [INDEX_LEN-1:0] w_u_ghr_ext;
    logic [INDEX_LEN-1:0] w_q_idx;
    logic [INDEX_LEN-1:0] w_u_idx;
    logic [CNT_W-1:0]     w_q_cnt;
    logic [CNT_W-1:0]     w_u_cnt;
    logic [CNT_W-1:0]     w_u_cnt_d;
    logic [GHR_LEN-1:0]   w_ghr_spec;
    logic [GHR_LEN-1:0]   w_ghr_repair;
    inst_kind_e           w_kind;
    logic                 w_is_br;
    logic                 w_repair;
    logic                 w_unused;

    // History is zero-extended into the upper index bits when shorter.
    always_comb begin
        w_q_ghr_ext                = '0;
        w_q_ghr_ext[GHR_LEN-1:0]   = r_ghr_q;
        w_u_ghr_ext                = '0;
        w_u_ghr_ext[GHR_LEN-1:0]   = upd_ghr;
    end

    generate
        if (GSHARE != 0) begin : g_gshare_idx
            assign w_q_idx = query_pc[INDEX_LEN+1:2] ^ w_q_ghr_ext;
            assign w_u_idx = upd_pc[INDEX_LEN+1:2] ^ w_u_ghr_ext;
        end else begin : g_bimodal_idx
            assign w_q_idx = query_pc[INDEX_LEN+1:2];
            assign w_u_idx = upd_pc[INDEX_LEN+1:2];
        end
    endgenerate

    always_comb begin
        w_kind         = decode_kind(query_inst);
        w_is_br        = (w_kind == INST_BR);
        w_q_cnt        = r_table_q[w_q_idx];
        predicted_jump = c_FALSE;
        predicted_imm  = imm_b(query_inst);
        case (w_kind)
            INST_JAL: begin
                predicted_jump = c_TRUE;
                predicted_imm  = imm_j(query_inst);
            end
            INST_BR: begin
                predicted_jump = w_q_cnt[CNT_W-1];
            end
            default: begin
                predicted_jump = c_FALSE;
            end
        endcase
    end

    assign predicted_ghr = r_ghr_q;

    generate
        if (GHR_LEN > 1) begin : g_ghr_shift
            assign w_ghr_spec   = {r_ghr_q[GHR_LEN-2:0], predicted_jump};
            assign w_ghr_repair = {upd_ghr[GHR_LEN-2:0], upd_taken};
        end else begin : g_ghr_bit
            assign w_ghr_spec   = predicted_jump;
            assign w_ghr_repair = upd_taken;
        end
    endgenerate

    assign w_u_cnt = r_table_q[w_u_idx];

    sat_counter_next #(
        .CNT_W (CNT_W)
    ) u_sat_counter_next (
        .i_cnt (w_u_cnt),
        .i_inc (upd_taken),
        .o_cnt (w_u_cnt_d)
    );

    assign w_repair = upd_valid & upd_mispredict;

    // A repair wins over the speculative shift of the same cycle.
    always_comb begin
        w_ghr_d = r_ghr_q;
        if (w_repair) begin
            w_ghr_d = w_ghr_repair;
        end else if (query_valid && w_is_br) begin
            w_ghr_d = w_ghr_spec;
        end

        w_branches_d = r_branches_q;
        if (upd_valid && (r_branches_q != c_STAT_MAX)) begin
            w_branches_d = r_branches_q + 32'd1;
        end

        w_mispredicts_d = r_mispredicts_q;
        if (w_repair && (r_mispredicts_q != c_STAT_MAX)) begin
            w_mispredicts_d = r_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_table_q[i] <= c_CNT_RESET;
            end
            r_ghr_q         <= '0;
            r_branches_q    <= '0;
            r_mispredicts_q <= '0;
        end else begin
            if (upd_valid) begin
                r_table_q[w_u_idx] <= w_u_cnt_d;
            end
            r_ghr_q         <= w_ghr_d;
            r_branches_q    <= w_branches_d;
            r_mispredicts_q <= w_mispredicts_d;
        end
    end

    assign stat_branches    = r_branches_q;
    assign stat_mispredicts = r_mispredicts_q;

    assign w_unused = ^{query_pc[31:INDEX_LEN+2], query_pc[1:0],
                        upd_pc[31:INDEX_LEN+2], upd_pc[1:0],
                        w_q_ghr_ext, w_u_ghr_ext};

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_predictor
// Description : Scoreboard bench for gshare_predictor (gshare, 8-bit index,
//               2-bit counters, 8-bit history).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_ALU  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_valid;
    logic [31:0] query_pc;
    logic [31:0] query_inst;
    logic        predicted_jump;
    logic [31:0] predicted_imm;
    logic [7:0]  predicted_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    gshare_predictor #(
        .INDEX_LEN (8),
        .CNT_W     (2),
        .GHR_LEN   (8),
        .GSHARE    (1)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .query_valid      (query_valid),
        .query_pc         (query_pc),
        .query_inst       (query_inst),
        .predicted_jump   (predicted_jump),
        .predicted_imm    (predicted_imm),
        .predicted_ghr    (predicted_ghr),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_ghr          (upd_ghr),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic        jump;
        logic [31:0] imm;
        logic [7:0]  ghr;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned m_tab [256];
    logic [7:0]  m_ghr = '0;
    logic [31:0] m_br  = '0;
    logic [31:0] m_mis = '0;
    bit          m_valid = 1'b0;
    logic        obs_jump;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [6:0] op,
                                          input logic [31:0] fill);
        logic [31:0] r;
        r        = fill;
        r[6:0]   = op;
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
        return r;
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [31:0] fill);
        logic [31:0] r;
        r        = fill;
        r[6:0]   = c_OP_JAL;
        r[31]    = imm[20];
        r[30:21] = imm[10:1];
        r[20]    = imm[11];
        r[19:12] = imm[19:12];
        return r;
    endfunction

    // Drive one cycle: push the model's expectation, compare before the edge,
    // then advance the model as the DUT will on the rising edge.
    task automatic step(input logic r, input logic qv, input logic [31:0] qpc,
                        input logic [31:0] qinst, input logic [31:0] qimm,
                        input logic uv, input logic [31:0] upc, input logic [7:0] ughr,
                        input logic ut, input logic um);
        exp_t       e;
        exp_t       got;
        logic [7:0] qi;
        logic [7:0] ui;
        logic [6:0] op;
        logic       pj;
        rst            = r;
        query_valid    = qv;
        query_pc       = qpc;
        query_inst     = qinst;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_ghr        = ughr;
        upd_taken      = ut;
        upd_mispredict = um;

        op = qinst[6:0];
        qi = qpc[9:2] ^ m_ghr;
        pj = 1'b0;
        if (op == c_OP_JAL) pj = 1'b1;
        else if (op == c_OP_BR) pj = (m_tab[qi] >= 2);
        e.jump = pj;
        e.imm  = qimm;
        e.ghr  = m_ghr;
        e.br   = m_br;
        e.mis  = m_mis;
        sb_q.push_back(e);

        #2;
        got      = sb_q.pop_front();
        obs_jump = predicted_jump;
        if (m_valid) begin
            check("jump", {31'd0, predicted_jump}, {31'd0, got.jump});
            check("imm", predicted_imm, got.imm);
            check("ghr", {24'd0, predicted_ghr}, {24'd0, got.ghr});
            check("branches", stat_branches, got.br);
            check("mispredicts", stat_mispredicts, got.mis);
        end

        if (r) begin
            for (int i = 0; i < 256; i++) m_tab[i] = 1;
            m_ghr   = '0;
            m_br    = '0;
            m_mis   = '0;
            m_valid = 1'b1;
        end else begin
            if (uv) begin
                ui = upc[9:2] ^ ughr;
                if (ut) begin
                    if (m_tab[ui] < 3) m_tab[ui] = m_tab[ui] + 1;
                end else if (m_tab[ui] > 0) begin
                    m_tab[ui] = m_tab[ui] - 1;
                end
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (um && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            end
            if (uv && um) m_ghr = {ughr[6:0], ut};
            else if (qv && op == c_OP_BR) m_ghr = {m_ghr[6:0], pj};
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'd0, enc_b(13'd0, c_OP_ALU, 32'd0), 32'd0,
             1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] ghr, input logic t, input logic m);
        step(1'b0, 1'b0, 32'd0, enc_b(13'd0, c_OP_ALU, 32'd0), 32'd0,
             1'b1, pc, ghr, t, m);
    endtask

    task automatic query_br(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, enc_b(13'h010, c_OP_BR, 32'h0020_8000), 32'h0000_0010,
             1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic rand_step(input logic force_upd);
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [20:0] jv;
        logic [12:0] bv;
        int          sel;
        pc  = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
        sel = $urandom_range(0, 4);
        jv  = 21'($urandom) & 21'h1F_FFFE;
        bv  = 13'($urandom) & 13'h1FFE;
        if (sel == 0) begin
            inst = enc_j(jv, $urandom);
            imm  = {{11{jv[20]}}, jv};
        end else begin
            inst = enc_b(bv, (sel <= 2) ? c_OP_BR : ((sel == 3) ? c_OP_JALR : c_OP_ALU), $urandom);
            imm  = {{19{bv[12]}}, bv};
        end
        step(1'b0, 1'($urandom_range(0, 1)), pc, inst, imm,
             force_upd | 1'($urandom_range(0, 1)),
             32'h0000_1000 | (32'($urandom_range(0, 15)) << 2),
             8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        rst = 1'b1; query_valid = 1'b0; query_pc = '0; query_inst = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        @(negedge clk);
        do_reset();
        do_reset();

        query_br(32'h100);
        check("rst_pred", {31'd0, obs_jump}, 32'd0);
        check("rst_ghr", {24'd0, predicted_ghr}, 32'd0);
        step(1'b0, 1'b1, 32'h100, enc_j(21'h1F_FFF8, 32'h0000_0080), 32'hFFFF_FFF8,
             1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
        check("jal_jump", {31'd0, obs_jump}, 32'd1);
        check("jal_ghr", {24'd0, predicted_ghr}, 32'd0);

        // Train entry 0x40, then build history 0x01 through it.
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        upd(32'h100, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) query_br(32'h200);
        query_br(32'h100);
        check("trained_pred", {31'd0, obs_jump}, 32'd1);
        check("ghr_01", {24'd0, predicted_ghr}, 32'h01);
        query_br(32'h104);
        check("gshare_idx", {31'd0, obs_jump}, 32'd1);

        for (int i = 0; i < 4; i++) upd(32'h100, 8'h00, 1'b1, 1'b0);
        upd(32'h100, 8'h00, 1'b0, 1'b0);
        query_br(32'h10C);
        check("sat_hold", {31'd0, obs_jump}, 32'd1);

        step(1'b0, 1'b1, 32'h300, enc_b(13'h010, c_OP_BR, 32'd0), 32'h10,
             1'b1, 32'h200, 8'h0F, 1'b1, 1'b1);
        check("repair_ghr", {24'd0, predicted_ghr}, 32'h1F);

        do_reset();
        step(1'b0, 1'b1, 32'h300, enc_b(13'h010, c_OP_BR, 32'd0), 32'h10,
             1'b1, 32'h300, 8'h00, 1'b1, 1'b0);
        check("same_cycle_old", {31'd0, obs_jump}, 32'd0);
        query_br(32'h300);
        check("same_cycle_new", {31'd0, obs_jump}, 32'd1);

        for (int i = 0; i < 300; i++) rand_step(1'b0);

        for (int i = 0; i < 10; i++) rand_step(1'b1);
        step(1'b1, 1'b1, 32'h100, enc_b(13'h010, c_OP_BR, 32'd0), 32'h10,
             1'b1, 32'h100, 8'h00, 1'b1, 1'b1);
        check("mid_rst_br", stat_branches, 32'd0);
        check("mid_rst_mis", stat_mispredicts, 32'd0);
        check("mid_rst_ghr", {24'd0, predicted_ghr}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            query_br(32'h1000 + 32'(k) * 32'h40);
            check("mid_rst_pred", {31'd0, obs_jump}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
